ps2_cmd_ctrl: RTL and testbench

PS2_CMD_CTRL -- requirements
Module: ps2_cmd_ctrl

---
 rtl/ps2_pkg.sv | 35 +++
 rtl/ps2_timeout.sv | 28 ++
 rtl/ps2_cmd_ctrl.sv | 154 +++++++++++++++
 tb/tb_ps2_cmd_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 constants: protocol bytes, lock-key make codes, controller state encodings.
package ps2_pkg;

  localparam logic [7:0] ACK     = 8'hFA;
  localparam logic [7:0] RESEND  = 8'hFE;
  localparam logic [7:0] BREAK   = 8'hF0;
  localparam logic [7:0] EXT     = 8'hE0;
  localparam logic [7:0] SET_LED = 8'hED;

  localparam logic [7:0] KEY_SCROLL = 8'h7E;
  localparam logic [7:0] KEY_NUM    = 8'h77;
  localparam logic [7:0] KEY_CAPS   = 8'h58;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SEND_CMD  = 3'd1;
  localparam logic [2:0] ST_WAIT_ACK1 = 3'd2;
  localparam logic [2:0] ST_SEND_ARG  = 3'd3;
  localparam logic [2:0] ST_WAIT_ACK2 = 3'd4;
  localparam logic [2:0] ST_DONE      = 3'd5;
  localparam logic [2:0] ST_FAIL      = 3'd6;

  // LED bit toggled by a lock-key make code; zero for any other byte.
  function automatic logic [2:0] led_toggle_mask(input logic [7:0] code);
    logic [2:0] mask;
    mask = '0;
    case (code)
      KEY_SCROLL: mask = 3'b001;
      KEY_NUM:    mask = 3'b010;
      KEY_CAPS:   mask = 3'b100;
      default:    mask = '0;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/ps2_timeout.sv
// Response timer: cleared by start, counts while run, expire asserts on the last allowed cycle.
module ps2_timeout #(
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic run,
  output logic expire
);

  localparam int unsigned CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] count;

  assign expire = run && (count == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (start) begin
      count <= '0;
    end else if (run && !expire) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/ps2_cmd_ctrl.sv
// PS/2 keyboard command sequencer with ACK/RESEND retry, response timeout and scan-byte forwarding.
// Optional lock-key LED tracking and automatic SET_LED commands: define PS2_CMD_CTRL_LED_SYNC_EN.
module ps2_cmd_ctrl
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 50000,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_code,
  input  logic       cmd_has_arg,
  input  logic [7:0] cmd_arg,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       rx_err,
  output logic       scan_valid,
  output logic [7:0] scan_data,
  output logic       busy,
  output logic       done,
  output logic       fail,
  output logic [2:0] led_state
);

  localparam int unsigned RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  logic [2:0]    state, state_nx;
  logic [7:0]    code_r, arg_r;
  logic          has_arg_r, internal_r;
  logic [RW-1:0] retry;
  logic          in_wait, rx_ack, rx_resend, rx_fwd, can_retry;
  logic          tx_hs, expire, accept_ext, accept_int;
  logic [2:0]    led_r;

  assign in_wait    = (state == ST_WAIT_ACK1) || (state == ST_WAIT_ACK2);
  assign rx_ack     = in_wait && rx_valid && !rx_err && (rx_data == ACK);
  assign rx_resend  = in_wait && rx_valid && (rx_err || (rx_data == RESEND));
  assign rx_fwd     = rx_valid && !rx_err && !(in_wait && ((rx_data == ACK) || (rx_data == RESEND)));
  assign can_retry  = 32'(retry) < MAX_RETRY;
  assign accept_ext = (state == ST_IDLE) && cmd_valid;

  assign cmd_ready = (state == ST_IDLE);
  assign tx_valid  = (state == ST_SEND_CMD) || (state == ST_SEND_ARG);
  assign tx_data   = (state == ST_SEND_ARG) ? arg_r : code_r;
  assign tx_hs     = tx_valid && tx_ready;
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE) && !internal_r;
  assign fail      = (state == ST_FAIL) && !internal_r;
  assign led_state = led_r;

  ps2_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .start  (tx_hs),
    .run    (in_wait),
    .expire (expire)
  );

  // A valid response takes priority over a timeout expiring in the same cycle.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:      if (accept_ext || accept_int) state_nx = ST_SEND_CMD;
      ST_SEND_CMD:  if (tx_ready) state_nx = ST_WAIT_ACK1;
      ST_WAIT_ACK1: begin
        if (rx_ack)         state_nx = has_arg_r ? ST_SEND_ARG : ST_DONE;
        else if (rx_resend) state_nx = can_retry ? ST_SEND_CMD : ST_FAIL;
        else if (expire)    state_nx = ST_FAIL;
      end
      ST_SEND_ARG:  if (tx_ready) state_nx = ST_WAIT_ACK2;
      ST_WAIT_ACK2: begin
        if (rx_ack)         state_nx = ST_DONE;
        else if (rx_resend) state_nx = can_retry ? ST_SEND_ARG : ST_FAIL;
        else if (expire)    state_nx = ST_FAIL;
      end
      default:      state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      retry      <= '0;
      code_r     <= '0;
      arg_r      <= '0;
      has_arg_r  <= 1'b0;
      internal_r <= 1'b0;
      scan_valid <= 1'b0;
      scan_data  <= '0;
    end else begin
      state <= state_nx;
      if (accept_ext) begin
        code_r     <= cmd_code;
        arg_r      <= cmd_arg;
        has_arg_r  <= cmd_has_arg;
        internal_r <= 1'b0;
        retry      <= '0;
      end else if (accept_int) begin
        code_r     <= SET_LED;
        arg_r      <= {5'b0, led_r};
        has_arg_r  <= 1'b1;
        internal_r <= 1'b1;
        retry      <= '0;
      end else if (rx_resend && can_retry) begin
        retry <= retry + RW'(1);
      end
      scan_valid <= rx_fwd;
      if (rx_fwd) scan_data <= rx_data;
    end
  end

`ifdef PS2_CMD_CTRL_LED_SYNC_EN
  logic       pending, brk_seen, ext_seen;
  logic [2:0] key_mask;

  assign key_mask   = led_toggle_mask(rx_data);
  assign accept_int = (state == ST_IDLE) && !cmd_valid && pending;

  // Setting pending after the clear lets a key arriving at acceptance queue another update.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_r    <= '0;
      pending  <= 1'b0;
      brk_seen <= 1'b0;
      ext_seen <= 1'b0;
    end else begin
      if (accept_int) pending <= 1'b0;
      if (rx_fwd) begin
        if (rx_data == BREAK) begin
          brk_seen <= 1'b1;
        end else if (rx_data == EXT) begin
          ext_seen <= 1'b1;
        end else begin
          brk_seen <= 1'b0;
          ext_seen <= 1'b0;
          if (!brk_seen && !ext_seen && (key_mask != '0)) begin
            led_r   <= led_r ^ key_mask;
            pending <= 1'b1;
          end
        end
      end
    end
  end
`else
  assign accept_int = 1'b0;
  assign led_r      = '0;
`endif

endmodule

// File: tb/tb_ps2_cmd_ctrl.sv
// Self-checking bench for ps2_cmd_ctrl: table-driven command/response vectors plus hand sequences.
module tb_ps2_cmd_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_has_arg;
  logic [7:0] cmd_code, cmd_arg;
  logic       tx_valid, tx_ready;
  logic [7:0] tx_data;
  logic       rx_valid, rx_err;
  logic [7:0] rx_data;
  logic       scan_valid;
  logic [7:0] scan_data;
  logic       busy, done, fail;
  logic [2:0] led_state;

  always #5 clk = ~clk;

  ps2_cmd_ctrl #(.TIMEOUT_CYC(100), .MAX_RETRY(3)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_code(cmd_code),
    .cmd_has_arg(cmd_has_arg), .cmd_arg(cmd_arg),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_err(rx_err),
    .scan_valid(scan_valid), .scan_data(scan_data),
    .busy(busy), .done(done), .fail(fail), .led_state(led_state)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [7:0] txq[$];
  int tx_cnt = 0, done_cnt = 0, fail_cnt = 0, scan_cnt = 0;
  int hs_cyc = 0, fail_cyc = 0;
  logic [7:0] last_scan = 8'h00;

  always @(negedge clk) begin
    if (tx_valid && tx_ready) begin
      txq.push_back(tx_data);
      tx_cnt++;
      hs_cyc = cyc;
    end
    if (done) done_cnt++;
    if (fail) begin
      fail_cnt++;
      fail_cyc = cyc;
    end
    if (scan_valid) begin
      scan_cnt++;
      last_scan = scan_data;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, got hang expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_rx(input logic [7:0] d, input logic e);
    rx_valid = 1'b1;
    rx_data  = d;
    rx_err   = e;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_err   = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic issue(input logic [7:0] code, input logic has_arg, input logic [7:0] arg);
    cmd_valid   = 1'b1;
    cmd_code    = code;
    cmd_has_arg = has_arg;
    cmd_arg     = arg;
    @(negedge clk);
    cmd_valid   = 1'b0;
  endtask

  task automatic get_tx(input string name, output logic [7:0] b, output bit ok);
    int n;
    ok = 1'b0;
    b  = 8'h00;
    n  = 0;
    while (!ok && n < 30) begin
      if (txq.size() > 0) begin
        b  = txq.pop_front();
        ok = 1'b1;
      end else begin
        @(negedge clk);
        n++;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s: got no tx byte expected one within 30 cycles", name);
    end
  endtask

  typedef struct {
    logic [7:0]      code;
    logic            has_arg;
    logic [7:0]      arg;
    int              nresp;
    logic [0:4][7:0] resp;
    logic [0:4]      err;
    logic [0:4][7:0] tx;
    int              ntx;
    int              exp_done;
    int              exp_fail;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [7:0] b;
    bit ok;
    int d0, f0, t0, s0;

    vecs[0] = '{8'hED, 1'b1, 8'h02, 2, {8'hFA, 8'hFA, 8'h00, 8'h00, 8'h00}, 5'b00000,
                {8'hED, 8'h02, 8'h00, 8'h00, 8'h00}, 2, 1, 0};
    vecs[1] = '{8'hF4, 1'b0, 8'h00, 2, {8'hFE, 8'hFA, 8'h00, 8'h00, 8'h00}, 5'b00000,
                {8'hF4, 8'hF4, 8'h00, 8'h00, 8'h00}, 2, 1, 0};
    vecs[2] = '{8'hFF, 1'b0, 8'h00, 4, {8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'h00}, 5'b00000,
                {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00}, 4, 0, 1};
    vecs[3] = '{8'hED, 1'b1, 8'h07, 3, {8'hFA, 8'hFE, 8'hFA, 8'h00, 8'h00}, 5'b00000,
                {8'hED, 8'h07, 8'h07, 8'h00, 8'h00}, 3, 1, 0};
    vecs[4] = '{8'hF3, 1'b1, 8'h20, 5, {8'h00, 8'hFA, 8'hFE, 8'hFE, 8'hFE}, 5'b10000,
                {8'hF3, 8'hF3, 8'h20, 8'h20, 8'h20}, 5, 0, 1};

    rst = 1'b1; cmd_valid = 1'b0; cmd_code = 8'h00; cmd_has_arg = 1'b0; cmd_arg = 8'h00;
    tx_ready = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; rx_err = 1'b0;
    idle(3);
    check("reset_cmd_ready", cmd_ready, 1);
    check("reset_busy", busy, 0);
    check("reset_tx_valid", tx_valid, 0);
    check("reset_scan_valid", scan_valid, 0);
    check("reset_scan_data", scan_data, 8'h00);
    check("reset_led_state", led_state, 3'b000);
    check("reset_done_fail", {done, fail}, 0);
    rst = 1'b0;
    idle(2);

    for (int v = 0; v < 5; v++) begin
      d0 = done_cnt; f0 = fail_cnt; t0 = tx_cnt;
      issue(vecs[v].code, vecs[v].has_arg, vecs[v].arg);
      for (int k = 0; k < vecs[v].nresp; k++) begin
        get_tx($sformatf("v%0d_tx%0d_wait", v, k), b, ok);
        if (ok) begin
          check($sformatf("v%0d_tx%0d_byte", v, k), b, vecs[v].tx[k]);
          pulse_rx(vecs[v].resp[k], vecs[v].err[k]);
        end
      end
      idle(4);
      check($sformatf("v%0d_tx_count", v), tx_cnt - t0, vecs[v].ntx);
      check($sformatf("v%0d_done", v), done_cnt - d0, vecs[v].exp_done);
      check($sformatf("v%0d_fail", v), fail_cnt - f0, vecs[v].exp_fail);
      check($sformatf("v%0d_busy_after", v), busy, 0);
    end

    // Timeout: fail 100 cycles after the command handshake enters WAIT_ACK1.
    f0 = fail_cnt;
    issue(8'hF4, 1'b0, 8'h00);
    get_tx("timeout_tx_wait", b, ok);
    check("timeout_tx_byte", b, 8'hF4);
    idle(115);
    check("timeout_fail_count", fail_cnt - f0, 1);
    check("timeout_fail_latency", fail_cyc - (hs_cyc + 1), 100);
    check("timeout_busy_after", busy, 0);

    // Non-response byte while waiting is forwarded and the wait continues.
    d0 = done_cnt; s0 = scan_cnt;
    issue(8'hF4, 1'b0, 8'h00);
    get_tx("scanwait_tx_wait", b, ok);
    pulse_rx(8'h1C, 1'b0);
    idle(1);
    check("scanwait_scan_count", scan_cnt - s0, 1);
    check("scanwait_scan_data", last_scan, 8'h1C);
    check("scanwait_still_busy", busy, 1);
    check("scanwait_no_done_yet", done_cnt - d0, 0);
    pulse_rx(8'hFA, 1'b0);
    idle(3);
    check("scanwait_done", done_cnt - d0, 1);
    check("scanwait_ack_not_forwarded", scan_cnt - s0, 1);

    // Outside WAIT_ACK*: errored bytes dropped, clean bytes forwarded.
    s0 = scan_cnt;
    pulse_rx(8'h55, 1'b1);
    pulse_rx(8'h33, 1'b0);
    idle(2);
    check("idle_scan_count", scan_cnt - s0, 1);
    check("idle_scan_data", scan_data, 8'h33);

    // Reset mid-command aborts silently.
    d0 = done_cnt; f0 = fail_cnt;
    issue(8'hF2, 1'b0, 8'h00);
    get_tx("abort_tx_wait", b, ok);
    idle(1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(3);
    check("abort_no_pulse", (done_cnt - d0) + (fail_cnt - f0), 0);
    check("abort_cmd_ready", cmd_ready, 1);
    check("abort_tx_valid", tx_valid, 0);
    txq.delete();

`ifdef PS2_CMD_CTRL_LED_SYNC_EN
    d0 = done_cnt; f0 = fail_cnt; t0 = tx_cnt;
    pulse_rx(8'h58, 1'b0);
    pulse_rx(8'hF0, 1'b0);
    pulse_rx(8'h58, 1'b0);
    get_tx("led_tx0_wait", b, ok);
    check("led_tx0_byte", b, 8'hED);
    pulse_rx(8'hFA, 1'b0);
    get_tx("led_tx1_wait", b, ok);
    check("led_tx1_byte", b, 8'h04);
    pulse_rx(8'hFA, 1'b0);
    idle(4);
    check("led_state_caps", led_state, 3'b100);
    check("led_tx_count", tx_cnt - t0, 2);
    check("led_no_done", done_cnt - d0, 0);
    check("led_no_fail", fail_cnt - f0, 0);
    check("led_busy_after", busy, 0);
`else
    t0 = tx_cnt;
    pulse_rx(8'h58, 1'b0);
    idle(4);
    check("noled_state", led_state, 3'b000);
    check("noled_no_tx", tx_cnt - t0, 0);
    check("noled_busy", busy, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
